// File: rtl/debounce_sync_2ch_if.sv
// Raw inputs and conditioned outputs of the
// two-channel debounce front end.
interface debounce_sync_2ch_if;
  logic a_raw;
  logic b_raw;
  logic a_db;
  logic b_db;
  logic a_rise;
  logic a_fall;
  logic b_rise;
  logic b_fall;

  modport master (
    output a_raw,
    output b_raw,
    input  a_db,
    input  b_db,
    input  a_rise,
    input  a_fall,
    input  b_rise,
    input  b_fall
  );

  modport slave (
    input  a_raw,
    input  b_raw,
    output a_db,
    output b_db,
    output a_rise,
    output a_fall,
    output b_rise,
    output b_fall
  );
endinterface

// File: rtl/debounce_sync_2ch.sv
// Two independent sync + debounce channels feeding
// the OR gate inputs, with 1-cycle edge strobes.
module debounce_sync_ch #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000
) (
  input  logic clk,
  input  logic rst,
  input  logic raw,
  output logic db,
  output logic rise,
  output logic fall
);
  localparam logic [CNT_W-1:0] LAST =
    CNT_W'(STABLE_CNT - 1);

  logic             s1;
  logic             s2;
  logic [CNT_W-1:0] cnt;
  logic             mis;
  logic             hit;

  // Two-flop synchroniser; only s2 is used downstream.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
    end else begin
      s1 <= raw;
      s2 <= s1;
    end
  end

  // Mismatch and terminal-count decode from registered state.
  always_comb begin
    mis = (s2 != db);
    hit = mis && (cnt == LAST);
  end

  // Stability counter, accepted level and edge strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt  <= '0;
      db   <= 1'b0;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      rise <= 1'b0;
      fall <= 1'b0;
      unique case (1'b1)
        !mis: begin
          cnt <= '0;
        end
        hit: begin
          cnt  <= '0;
          db   <= s2;
          rise <= s2;
          fall <= ~s2;
        end
        default: begin
          cnt <= cnt + 1'b1;
        end
      endcase
    end
  end
endmodule

module debounce_sync_2ch #(
  parameter int CNT_W      = 16,
  parameter int STABLE_CNT = 50000
) (
  input logic          clk,
  input logic          rst,
  debounce_sync_2ch_if.slave io
);
  logic a_db;
  logic a_rise;
  logic a_fall;
  logic b_db;
  logic b_rise;
  logic b_fall;

  debounce_sync_ch #(
    .CNT_W      (CNT_W),
    .STABLE_CNT (STABLE_CNT)
  ) u_a (
    .clk  (clk),
    .rst  (rst),
    .raw  (io.a_raw),
    .db   (a_db),
    .rise (a_rise),
    .fall (a_fall)
  );

  debounce_sync_ch #(
    .CNT_W      (CNT_W),
    .STABLE_CNT (STABLE_CNT)
  ) u_b (
    .clk  (clk),
    .rst  (rst),
    .raw  (io.b_raw),
    .db   (b_db),
    .rise (b_rise),
    .fall (b_fall)
  );

  // Outputs are straight from flops; no input-to-output path.
  always_comb begin
    io.a_db   = a_db;
    io.a_rise = a_rise;
    io.a_fall = a_fall;
    io.b_db   = b_db;
    io.b_rise = b_rise;
    io.b_fall = b_fall;
  end
endmodule
